operand_loader: RTL
===================

Name: operand_loader

Overview:
- Upstream operand-entry stage for the 7-segment adder display.
- Captures two 8-bit operands from slide switches under control of a bouncy "load" push-button, and toggles the add/sub select from a second push-button.
- Drives the adder/display stage's A, B and Sel inputs, plus a valid flag and phase LEDs.
- Contains a debounce/one-shot path per button and a 3-state entry FSM.

Parameters:
- W, 8, operand width in bits.
- DEB_CYCLES, 1000000, stable-level cycles required before a button change is accepted (20 ms at 50 MHz); benches override to 4.

Ports:
- CLK_50  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- sw  input  W  operand switches (asynchronous, slow).
- btn_load  input  1  raw load button, active-high, bouncy.
- btn_sel  input  1  raw select button, active-high, bouncy.
- A  output  W  operand A to adder/display stage.
- B  output  W  operand B to adder/display stage.
- Sel  output  1  operation select to adder/display stage.
- valid  output  1  high while both operands are entered (SHOW state).
- phase  output  2  entry phase for LEDs: 00 LOAD_A, 01 LOAD_B, 10 SHOW.

Behaviour:
- Reset is asynchronous and active-high, on rst high:
  - A=0, B=0, Sel=0, valid=0, phase=00.
  - FSM in LOAD_A.
  - Debounce counters 0, synchronizers 0, stable levels 0, sw_q=0.
- Reset mid-operation aborts any entry and clears all operands immediately; there is no partial capture.
- Input sampling:
  - sw registered once per clock into sw_q; all captures use sw_q.
  - Each button passes through a 2-FF synchronizer: s1<=raw, s2<=s1.
- Debounce, per button:
  - If s2==stable: cnt<=0.
  - Else if cnt==DEB_CYCLES-1: stable<=s2, cnt<=0.
  - Else: cnt<=cnt+1.
  - press is a registered pulse: press<=(s2 & ~stable & cnt==DEB_CYCLES-1).
- Press timing: press is exactly 1 cycle wide, only on an accepted 0->1 transition; release generates no pulse.
- Latency: raw rises and holds before edge 1 -> press high after edge DEB_CYCLES+2 -> FSM acts at edge DEB_CYCLES+3.
- A raw pulse or bounce shorter than DEB_CYCLES cycles at s2 is ignored and the counter restarts. Holding the button produces no repeat pulses.
- FSM, transitions on load press only:
  - LOAD_A: A<=sw_q -> LOAD_B.
  - LOAD_B: B<=sw_q -> SHOW.
  - SHOW: -> LOAD_A with no capture.
- A and B hold their previous values in all states until overwritten, so the display keeps showing the old result during re-entry.
- valid=1 only in SHOW; it is registered and asserts on the same edge the state becomes SHOW.
- phase is decoded from state, registered.
- Sel: each sel press toggles Sel on the next edge, in any state.
- Load and sel presses on the same cycle are independent; both take effect on the same edge.
- Counter width: ceil(log2(DEB_CYCLES)) bits, at least 1. DEB_CYCLES=1 means acceptance on the first differing cycle.
- No combinational path from any input to any output.

Decomposition:
- Shared package: state encoding (LOAD_A=2'b00, LOAD_B=2'b01, SHOW=2'b10), matching phase LED constants, default DEB_CYCLES and W.
- Sub-module btn_debounce (parameter DEB_CYCLES; ports CLK_50, rst, raw, level, press), instantiated twice.
- FSM, operand registers and Sel toggle live in operand_loader.

Test Plan (DEB_CYCLES=4, 10 ns clock):
- Reset: rst=1 for 3 cycles, then rst=0 -> A=0, B=0, Sel=0, valid=0, phase=00.
- Clean load: sw=8'hFF, btn_load high for 10 cycles before edge 1 -> press pulse after edge 6, A=8'hFF and phase=01 after edge 7. Then sw=8'h01 and a second press -> B=8'h01, phase=10, valid=1.
- Bounce rejection: btn_load toggled every 2 cycles for 20 cycles, then held low -> no press, A/B/phase unchanged. Then held high for 10 cycles -> exactly one capture.
- Re-entry: in SHOW (A=FF, B=01), press load -> phase=00, valid=0, A=FF and B=01 retained. Press with sw=8'h10 -> A=8'h10, phase=01.
- Sel toggle with simultaneous load: btn_sel and btn_load rise together in LOAD_B with sw=8'h22 -> same edge yields Sel=1, B=8'h22, phase=10. Another sel press -> Sel=0.
- Reset mid-entry: rst asserted asynchronously (between edges) in LOAD_B -> A=0, B=0, phase=00 immediately, before the next clock edge.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared types and defaults for the operand entry stage.
package operand_loader_pkg;

    localparam int DEF_W          = 8;
    localparam int DEF_DEB_CYCLES = 1000000;

    // Entry FSM encoding; the values double as the phase LED pattern.
    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        SHOW   = 2'b10
    } state_e;

    localparam logic [1:0] PHASE_LOAD_A = 2'b00;
    localparam logic [1:0] PHASE_LOAD_B = 2'b01;
    localparam logic [1:0] PHASE_SHOW   = 2'b10;

    // Map an entry state to its phase LED pattern.
    function automatic logic [1:0] phase_of(input state_e s);
        logic [1:0] p;
        case (s)
            LOAD_A:  p = PHASE_LOAD_A;
            LOAD_B:  p = PHASE_LOAD_B;
            SHOW:    p = PHASE_SHOW;
            default: p = PHASE_LOAD_A;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/operand_loader_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debounce, and a
// one-cycle press pulse on each accepted rising transition.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic CLK_50,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          stable_d, stable_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          press_d, press_q;

    // Debounce next-state: count consecutive cycles where the synchronized
    // input disagrees with the accepted level; any agreement restarts it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d = s2_q & ~stable_q & (cnt_q == LAST);
    end

    // Synchronizer, accepted level, counter and press pulse registers.
    always_ff @(posedge CLK_50 or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/operand_loader.sv
// Operand entry stage: captures A then B from the switches on debounced
// load presses, toggles Sel on select presses, and reports entry phase.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic         CLK_50,
    input  logic         rst,
    input  logic [W-1:0] sw,
    input  logic         btn_load,
    input  logic         btn_sel,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic         Sel,
    output logic         valid,
    output logic [1:0]   phase
);

    logic         load_press, sel_press;
    logic         load_level, sel_level;
    logic [W-1:0] sw_q;
    state_e       state_d, state_q;
    logic [W-1:0] a_d, a_q, b_d, b_q;
    logic         sel_d, sel_q;
    logic         valid_d, valid_q;
    logic [1:0]   phase_d, phase_q;

    // Accepted button levels are not needed here; only the press pulses are.
    logic unused_levels;
    assign unused_levels = load_level ^ sel_level;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_load (
        .CLK_50 (CLK_50),
        .rst    (rst),
        .raw    (btn_load),
        .level  (load_level),
        .press  (load_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sel (
        .CLK_50 (CLK_50),
        .rst    (rst),
        .raw    (btn_sel),
        .level  (sel_level),
        .press  (sel_press)
    );

    // Entry FSM next-state: operands hold until overwritten so the display
    // keeps the previous result during re-entry; valid/phase track the
    // upcoming state so they change on the same edge as the state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q ^ sel_press;
        if (load_press) begin
            case (state_q)
                LOAD_A: begin
                    a_d     = sw_q;
                    state_d = LOAD_B;
                end
                LOAD_B: begin
                    b_d     = sw_q;
                    state_d = SHOW;
                end
                default: state_d = LOAD_A;
            endcase
        end
        valid_d = (state_d == SHOW);
        phase_d = phase_of(state_d);
    end

    // Switch sampling, FSM state and registered outputs.
    always_ff @(posedge CLK_50 or posedge rst) begin
        if (rst) begin
            sw_q    <= '0;
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            phase_q <= PHASE_LOAD_A;
        end else begin
            sw_q    <= sw;
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            phase_q <= phase_d;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign Sel   = sel_q;
    assign valid = valid_q;
    assign phase = phase_q;

endmodule
